core_pipeline_ctrl: RTL

//  Parametrised stall/flush/freeze controller for the in-order core pipeline.

---
 rtl/core_pkg.sv | 15 +
 rtl/sat_counter.sv | 33 +++
 rtl/core_pipeline_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared pipeline stage indices and constants for the core
package core_pkg;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/core_pipeline_ctrl.sv
// rtl/core_pipeline_ctrl.sv - per-stage hold/bubble/flush control with freeze,
// deferred redirects and saturating performance counters
module core_pipeline_ctrl
    import core_pkg::*;
#(
    parameter int                    NUM_STAGES   = 5,
    parameter int                    NUM_SRC      = 4,
    parameter logic [NUM_SRC*3-1:0]  SRC_STAGE    = {3'd1, 3'd2, 3'd2, 3'd1},
    parameter int                    REDIRECT_STG = STG_MEM,
    parameter int                    BLOCK_HOLD   = 1,
    parameter int                    CNT_W        = CNT_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  instr_cache_blocking_n_i,
    input  logic                  data_cache_blocking_n_i,
    input  logic [NUM_SRC-1:0]    stall_req_i,
    input  logic                  redirect_i,
    input  logic                  cnt_clr_i,
    output logic [NUM_STAGES-1:0] hold_o,
    output logic [NUM_STAGES-1:0] bubble_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  wb_en_o,
    output logic [CNT_W-1:0]      cycle_cnt_o,
    output logic [CNT_W-1:0]      freeze_cnt_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    logic [2:0] hold_cnt_q, hold_cnt_d;
    logic       redirect_pend_q, redirect_pend_d;
    logic       freeze;
    logic       stall_any;
    logic [2:0] depth;
    logic       apply;

    // Returns {any stall, deepest stalled stage}; a busy I-cache stalls only IF.
    function automatic logic [3:0] stall_depth(input logic [NUM_SRC-1:0] req,
                                               input logic ic_busy);
        logic       valid;
        logic [2:0] k;
        valid = ic_busy;
        k     = 3'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req[i]) begin
                valid = 1'b1;
                if (SRC_STAGE[i*3 +: 3] > k) begin
                    k = SRC_STAGE[i*3 +: 3];
                end
            end
        end
        return {valid, k};
    endfunction

    always_comb begin
        freeze             = ~data_cache_blocking_n_i | (hold_cnt_q != 3'd0);
        {stall_any, depth} = stall_depth(stall_req_i, ~instr_cache_blocking_n_i);
        hold_o             = '0;
        bubble_o           = '0;
        flush_o            = '0;
        apply              = 1'b0;
        if (freeze) begin
            hold_o = '1;
        end else begin
            if (stall_any) begin
                for (int s = 0; s < NUM_STAGES; s++) begin
                    if (s <= int'(depth))     hold_o[s]   = 1'b1;
                    if (s == int'(depth) + 1) bubble_o[s] = 1'b1;
                end
            end
            apply = (redirect_i | redirect_pend_q) & ~hold_o[REDIRECT_STG];
            // Flushed stages load a NOP regardless of any hold or bubble there.
            if (apply) begin
                for (int s = STG_IF + 1; s <= REDIRECT_STG; s++) begin
                    flush_o[s]  = 1'b1;
                    hold_o[s]   = 1'b0;
                    bubble_o[s] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (!data_cache_blocking_n_i) begin
            hold_cnt_d = 3'(BLOCK_HOLD);
        end else if (hold_cnt_q != 3'd0) begin
            hold_cnt_d = hold_cnt_q - 3'd1;
        end
        redirect_pend_d = (redirect_i | redirect_pend_q) & ~apply;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_cnt_q      <= 3'd0;
            redirect_pend_q <= 1'b0;
        end else begin
            hold_cnt_q      <= hold_cnt_d;
            redirect_pend_q <= redirect_pend_d;
        end
    end

    assign wb_en_o = ~freeze;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (1'b1),
        .clr_i (cnt_clr_i),
        .cnt_o (cycle_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (freeze),
        .clr_i (cnt_clr_i),
        .cnt_o (freeze_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i ((|hold_o) & ~freeze),
        .clr_i (cnt_clr_i),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (apply),
        .clr_i (cnt_clr_i),
        .cnt_o (flush_cnt_o)
    );

endmodule
